tmerge_pack: RTL



---
 rtl/tmerge_pack.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tmerge_pack.sv
// tmerge_pack: compresses byte-enabled fragments into densely packed output words.
// Enabled input bytes are appended after the bytes already held in the accumulator;
// complete words are written out, an end-of-packet flushes the partial word with last=1,
// and a straddling end-of-packet spends one extra FLUSH cycle on the leftover bytes.
module tmerge_pack #(
    parameter int BYTES = 8
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [8*BYTES-1:0]   in_fifo_rd_data,
    input  logic [BYTES-1:0]     in_fifo_rd_be,
    input  logic                 in_fifo_rd_eop,
    input  logic                 in_fifo_ne,
    output logic                 in_fifo_re,
    output logic [8*BYTES-1:0]   packet_fifo_wr_data,
    output logic [BYTES-1:0]     packet_fifo_wr_be,
    output logic                 packet_fifo_wr_last,
    output logic                 packet_fifo_we,
    input  logic                 packet_fifo_full
);
    localparam int CW = $clog2(BYTES);          // holds 0..BYTES-1
    localparam int TW = CW + 1;                 // holds 0..2*BYTES-1
    localparam int AW = 8 * (BYTES - 1);        // accumulator width
    localparam int MW = 8 * (2 * BYTES - 1);    // merged accumulator + fragment
    localparam logic [TW-1:0] BYTES_T = TW'(BYTES);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [8*BYTES-1:0] data_q, data_d;
    logic [BYTES-1:0]   be_q, be_d;
    logic               last_q, last_d;
    logic               we_q, we_d;

    logic               accept;
    logic [AW-1:0]      acc_valid;
    logic [MW-1:0]      merged;
    logic [TW-1:0]      t_sum;

    // Low-aligned run of k ones.
    function automatic logic [BYTES-1:0] low_mask(input logic [TW-1:0] k);
        logic [BYTES-1:0] m;
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (TW'(i) < k);
        end
        return m;
    endfunction

    // Reset gates the pop so nothing is consumed while the packer is held in reset.
    assign accept     = reset_l && in_fifo_ne && !packet_fifo_full && (mode_q == RUN);
    assign in_fifo_re = accept;

    // Only the first cnt accumulator bytes are meaningful; mask the rest to zero so
    // partial words never expose stale bytes.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES - 1; gi++) begin : g_acc_mask
            assign acc_valid[8*gi +: 8] = (CW'(gi) < cnt_q) ? acc_q[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // Compress enabled lanes in ascending order directly after the held bytes.
    always_comb begin
        merged         = '0;
        merged[AW-1:0] = acc_valid;
        t_sum          = {1'b0, cnt_q};
        for (int i = 0; i < BYTES; i++) begin
            if (in_fifo_rd_be[i]) begin
                merged[8*t_sum +: 8] = in_fifo_rd_data[8*i +: 8];
                t_sum                = t_sum + 1'b1;
            end
        end
    end

    // Next-state and registered-output decisions; outputs hold unless a word is written.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        data_d = data_q;
        be_d   = be_q;
        last_d = last_q;
        we_d   = 1'b0;
        if (mode_q == FLUSH) begin
            if (!packet_fifo_full) begin
                we_d   = 1'b1;
                data_d = {8'h00, acc_valid};
                be_d   = low_mask({1'b0, cnt_q});
                last_d = 1'b1;
                cnt_d  = '0;
                acc_d  = '0;
                mode_d = RUN;
            end
        end else if (accept) begin
            if (t_sum < BYTES_T) begin
                if (!in_fifo_rd_eop) begin
                    cnt_d = t_sum[CW-1:0];
                    acc_d = merged[AW-1:0];
                end else if (t_sum != '0) begin
                    we_d   = 1'b1;
                    data_d = merged[8*BYTES-1:0];
                    be_d   = low_mask(t_sum);
                    last_d = 1'b1;
                    cnt_d  = '0;
                    acc_d  = '0;
                end
                // t_sum == 0 with eop: empty packet, silently dropped.
            end else begin
                we_d   = 1'b1;
                data_d = merged[8*BYTES-1:0];
                be_d   = '1;
                last_d = in_fifo_rd_eop && (t_sum == BYTES_T);
                acc_d  = merged[MW-1:8*BYTES];
                // BYTES is a power of two, so t_sum-BYTES is just the low bits.
                cnt_d  = t_sum[CW-1:0];
                if (in_fifo_rd_eop && (t_sum != BYTES_T)) begin
                    mode_d = FLUSH;
                end
            end
        end
    end

    // State and output registers; a mid-packet reset discards everything held.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            mode_q <= RUN;
            cnt_q  <= '0;
            acc_q  <= '0;
            data_q <= '0;
            be_q   <= '0;
            last_q <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            data_q <= data_d;
            be_q   <= be_d;
            last_q <= last_d;
            we_q   <= we_d;
        end
    end

    assign packet_fifo_wr_data = data_q;
    assign packet_fifo_wr_be   = be_q;
    assign packet_fifo_wr_last = last_q;
    assign packet_fifo_we      = we_q;

endmodule
